// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared types and helpers for the seven-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Width of one digit code fed to the shared decoder.
    localparam int SEG_DIGIT_W    = 4;

    // Upper bound on the digit count; sizes the all-off helper result.
    localparam int SEG_MAX_DIGITS = 8;

    // Slot phase: dark ghosting gap, then the digit's ON window.
    typedef enum logic [0:0] {
        GAP = 1'b0,
        ON  = 1'b1
    } seg_state_e;

    // All-anodes-off pattern for n digits (active-low enables, so all ones).
    function automatic logic [SEG_MAX_DIGITS-1:0] SEG_ALL_OFF(input int n);
        logic [SEG_MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < SEG_MAX_DIGITS; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : seg_slot_timer
// Brief    : Per-slot cycle counter with GAP/ON phase. gap_done and slot_done
//            are combinational strobes, high in the last cycle of each phase.
// Revision : 1.0 - initial release
// ============================================================================
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int SCAN_CYC = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active low
    output seg_state_e phase,
    output logic       gap_done,
    output logic       slot_done
);

    localparam int CNT_W = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    seg_state_e       state_q;
    seg_state_e       state_d;

    // The counter spans the whole slot; the phase flips at GAP_CYC-1 and wraps at SCAN_CYC-1.
    always_comb begin
        gap_done  = (state_q == GAP) && (cnt_q == GAP_LAST);
        slot_done = (state_q == ON)  && (cnt_q == SLOT_LAST);
        cnt_d     = slot_done ? '0 : (cnt_q + CNT_ONE);
        state_d   = state_q;
        if (gap_done) begin
            state_d = ON;
        end else if (slot_done) begin
            state_d = GAP;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            state_q <= GAP;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign phase = state_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Round-robin scan of DIGITS common-anode digits through one
//            shared decoder. New values enter via load/ack and are applied
//            only at frame boundaries so a frame never mixes old and new data.
//            Optional leading-zero blanking: define SEG_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_CYC = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic                          clk,
    input  logic                          rst,        // asynchronous, active low
    input  logic                          load,
    input  logic [SEG_DIGIT_W*DIGITS-1:0] digits_in,
    output logic                          ack,
    output logic [SEG_DIGIT_W-1:0]        code,
    output logic [DIGITS-1:0]             dig_sel,
    output logic                          frame_start
);

    localparam int DATA_W = SEG_DIGIT_W * DIGITS;
    localparam int IDX_W  = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE   = IDX_W'(1);
    localparam logic [SEG_MAX_DIGITS-1:0] ALL_OFF_W = SEG_ALL_OFF(DIGITS);

    seg_state_e phase;
    logic       gap_done;
    logic       slot_done;
    logic       on_nxt;
    logic       boundary;

    logic [IDX_W-1:0]       idx_q,           idx_d;
    logic [DATA_W-1:0]      active_q,        active_d;
    logic [DATA_W-1:0]      pending_q,       pending_d;
    logic                   pending_valid_q, pending_valid_d;
    logic                   ack_q,           ack_d;
    logic                   frame_start_q,   frame_start_d;
    logic [SEG_DIGIT_W-1:0] code_q,          code_d;
    logic [DIGITS-1:0]      dig_sel_q,       dig_sel_d;
    logic [DIGITS-1:0]      blank;

    seg_slot_timer #(
        .SCAN_CYC (SCAN_CYC),
        .GAP_CYC  (GAP_CYC)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .phase     (phase),
        .gap_done  (gap_done),
        .slot_done (slot_done)
    );

    // Digit index advances at each slot end; the wrap from the last digit is the frame boundary.
    always_comb begin
        boundary = slot_done && (idx_q == IDX_LAST);
        idx_d    = idx_q;
        if (slot_done) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_ONE);
        end
    end

    // Load/ack handshake: stage into pending mid-frame, commit to active only on the boundary.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (boundary) begin
            // A load sampled on the boundary itself wins over anything already pending.
            if (load) begin
                active_d = digits_in;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end
        ack_d         = boundary && (load || pending_valid_q);
        frame_start_d = boundary;
    end

`ifdef SEG_LZB_EN
    // Blank digit k>0 when it and every more-significant digit are zero.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero = run_zero && (active_d[k*SEG_DIGIT_W +: SEG_DIGIT_W] == '0);
            if (k > 0) begin
                blank[k] = run_zero;
            end
        end
    end
`else
    // Blanking disabled: every digit lights in its ON window.
    always_comb begin
        blank = '0;
    end
`endif

    // Outputs are computed from next-state values so the registers add no extra latency.
    always_comb begin
        on_nxt    = gap_done || ((phase == ON) && !slot_done);
        code_d    = active_d[idx_d*SEG_DIGIT_W +: SEG_DIGIT_W];
        dig_sel_d = ALL_OFF_W[DIGITS-1:0];
        if (on_nxt && !blank[idx_d]) begin
            dig_sel_d[idx_d] = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            ack_q           <= 1'b0;
            frame_start_q   <= 1'b0;
            code_q          <= '0;
            dig_sel_q       <= ALL_OFF_W[DIGITS-1:0];
        end else begin
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            ack_q           <= ack_d;
            frame_start_q   <= frame_start_d;
            code_q          <= code_d;
            dig_sel_q       <= dig_sel_d;
        end
    end

    assign ack         = ack_q;
    assign frame_start = frame_start_q;
    assign code        = code_q;
    assign dig_sel     = dig_sel_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one seven_segment decoder across DIGITS common-anode digits.
- Cycles round-robin through digit slots. Each slot is a short all-off ghosting gap followed by that digit's ON window.
- Takes new display values through a load/ack handshake. New values are applied only at a frame boundary, so a frame never shows mixed old and new data.
- Placement: between the system clock domain logic (counters/FSMs producing 4-bit codes) and the shared decoder plus anode pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_CYC, 50000, clk cycles per digit slot, including the gap.
- GAP_CYC, 500, all-anodes-off cycles at the start of each slot. Legal range is 1 <= GAP_CYC < SCAN_CYC.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst, input, 1, asynchronous active-low reset.
- load, input, 1, request to update the displayed value.
- digits_in, input, 4*DIGITS, new codes; digit k is bits [4k+3:4k], digit 0 is least significant.
- ack, output, 1, one-cycle pulse when the loaded value becomes active.
- code, output, 4, code of the currently scanned digit, fed to the decoder.
- dig_sel, output, DIGITS, active-low one-hot anode enables; all ones means every digit is off.
- frame_start, output, 1, one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=GAP, idx=0, slot counter=0.
  - active and pending registers are 0; pending_valid=0.
  - dig_sel all ones, code=0, ack=0, frame_start=0.
- FSM states:
  - GAP: dig_sel all ones. Leave for ON after GAP_CYC cycles.
  - ON: dig_sel has only bit idx low. Leave for GAP after SCAN_CYC-GAP_CYC cycles.
- Slot transitions:
  - On each ON->GAP transition, idx increments.
  - idx wraps from DIGITS-1 to 0; that wrap edge is the frame boundary.
- Output timing:
  - code = active[idx], registered, valid for the whole slot including the gap.
  - dig_sel is registered with zero extra latency relative to the state.
  - First ON window after reset release starts at cycle GAP_CYC.
- Frame period is exactly DIGITS*SCAN_CYC cycles.
- frame_start:
  - Pulses on the cycle after each boundary edge.
  - Does not pulse at reset release.
- Handshake rules:
  - load sampled high, not on a boundary edge: pending<=digits_in, pending_valid<=1.
  - A later load before the boundary overwrites pending. There is no ack for the overwritten value; last writer wins.
  - At the boundary edge with pending_valid=1: active<=pending, pending_valid<=0, ack pulses in the following cycle (same cycle as frame_start).
  - load high on the boundary edge itself: digits_in goes directly to active, overriding any pending value, and pending_valid clears. ack pulses as above.
  - Holding load high continuously is legal: one ack per frame, each applying the latest sample.
- Reset mid-frame: pending is discarded, no ack is issued, scan restarts at digit 0 in GAP.
- Width rules:
  - Slot counter is $clog2(SCAN_CYC) bits.
  - idx is $clog2(DIGITS) bits, minimum 1.
  - No arithmetic on digit data.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined:
  - During ON, digit k keeps dig_sel[k]=1 (stays dark) if k>0 and active digits k..DIGITS-1 are all 0.
  - Digit 0 is always lit.
  - Timing, frame_start and ack are unchanged.
- Undefined: every digit is lit during its ON window.

Decomposition:
- Package seg_pkg:
  - State enum {GAP, ON}.
  - Constant SEG_DIGIT_W=4.
  - Constant SEG_ALL_OFF (all-ones helper function sized by DIGITS).
- Sub-module seg_slot_timer:
  - Slot counter plus GAP/ON phase.
  - Emits gap_done and slot_done strobes.
- Top-level seg_scan_ctrl holds idx, the active/pending registers, the handshake and the blanking logic.

Test Plan (DIGITS=4, SCAN_CYC=8, GAP_CYC=2):
- Reset, then release: dig_sel=4'b1111 for cycles 0-1, then 4'b1110 for cycles 2-7, 4'b1111 at cycles 8-9, 4'b1101 at cycles 10-15. frame_start first pulses at cycle 32.
- load=1 for one cycle at cycle 5 with digits_in=16'h1234: active stays 0 during frame 0. At the cycle-32 boundary, code sequence becomes 4,3,2,1 and ack pulses together with frame_start.
- Loads at cycle 5 (16'hAAAA) and cycle 20 (16'h5555): frame 1 shows 5555; exactly one ack.
- load high exactly on the boundary edge with 16'h0F0F while 16'hAAAA is pending: active=0F0F, pending is cleared, one ack.
- rst asserted at cycle 20 with a load pending: outputs return to reset values immediately. After release, no ack is issued and active stays 0.
- SEG_LZB_EN defined, active=16'h0030: digits 2 and 3 stay dark, digits 0 and 1 are lit. With active=0, only digit 0 is lit.
